// File: rtl/fact_iter_unit_if.sv
// Handshake/bus bundle for the iterative factorial engine.
//   go, abort, in          : requester -> engine (start, cancel, operand n)
//   busy, done, error, cs  : engine status (state code on cs)
//   result                 : last completed result, all-ones after overflow
interface fact_iter_unit_if #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 32
);
  logic             go;
  logic             abort;
  logic [IN_W-1:0]  in;
  logic             busy;
  logic             done;
  logic             error;
  logic [2:0]       cs;
  logic [OUT_W-1:0] result;

  modport master (output go, abort, in, input busy, done, error, cs, result);
  modport slave  (input go, abort, in, output busy, done, error, cs, result);
endinterface

// File: rtl/fact_iter_unit.sv
// Iterative factorial engine: result = n! with one multiply per cycle,
// counting down from n to 2, with overflow detection against OUT_W bits.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fact_iter_unit_if slave (go/abort/in in; busy/done/error/cs/result out)
module fact_iter_unit #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  fact_iter_unit_if.slave  bus
);

  localparam int unsigned PROD_W = OUT_W + IN_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MULT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [IN_W-1:0]   n_q, n_nxt;
  logic [IN_W-1:0]   cnt, cnt_nxt;
  logic [OUT_W-1:0]  acc, acc_nxt;
  logic [OUT_W-1:0]  result_q, result_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              error_q, error_nxt;
  logic [PROD_W-1:0] prod;

  // Full-width product; any bit above OUT_W means the true value overflowed.
  assign prod = PROD_W'(acc) * PROD_W'(cnt);

  // Next-state and datapath update; abort outranks go.
  always_comb begin
    state_nxt  = state;
    n_nxt      = n_q;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    result_nxt = result_q;

    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.go) begin
            n_nxt     = bus.in;
            state_nxt = LOAD;
          end
        end
        LOAD: begin
          acc_nxt = OUT_W'(1);
          cnt_nxt = n_q;
          if (n_q <= IN_W'(1)) begin
            state_nxt  = DONE;
            result_nxt = OUT_W'(1);
          end else begin
            state_nxt = MULT;
          end
        end
        MULT: begin
          if (prod[PROD_W-1 -: IN_W] != '0) begin
            state_nxt  = ERR;
            result_nxt = '1;
          end else begin
            acc_nxt = prod[OUT_W-1:0];
            if (cnt == IN_W'(2)) begin
              state_nxt  = DONE;
              result_nxt = prod[OUT_W-1:0];
            end else begin
              cnt_nxt = cnt - IN_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt  = (state_nxt == LOAD) || (state_nxt == MULT);
    done_nxt  = (state_nxt == DONE);
    error_nxt = (state_nxt == ERR);
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_q      <= '0;
      cnt      <= '0;
      acc      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      n_q      <= n_nxt;
      cnt      <= cnt_nxt;
      acc      <= acc_nxt;
      result_q <= result_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      error_q  <= error_nxt;
    end
  end

  assign bus.cs     = state;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_fact_iter_unit.sv
// Directed self-checking bench for fact_iter_unit (32-bit and 16-bit result).
module tb_fact_iter_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fact_iter_unit_if #(.IN_W(4), .OUT_W(32)) bus32 ();
  fact_iter_unit_if #(.IN_W(4), .OUT_W(16)) bus16 ();

  fact_iter_unit #(.IN_W(4), .OUT_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  fact_iter_unit #(.IN_W(4), .OUT_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle go; returns edges counted from the accept edge until done/error.
  task automatic run32(input logic [3:0] n, output int edges);
    bus32.in = n;
    bus32.go = 1'b1;
    tick();
    edges = 1;
    bus32.go = 1'b0;
    bus32.in = ~n;
    check("acc32_cs_load", 64'(bus32.cs), 64'd1);
    check("acc32_busy", 64'(bus32.busy), 64'd1);
    while (!(bus32.done || bus32.error) && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic run16(input logic [3:0] n, output int edges);
    bus16.in = n;
    bus16.go = 1'b1;
    tick();
    edges = 1;
    bus16.go = 1'b0;
    bus16.in = ~n;
    while (!(bus16.done || bus16.error) && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int e;
    logic [2:0] pat [4];
    pat = '{3'd1, 3'd2, 3'd2, 3'd3};

    rst = 1'b1;
    bus32.go = 1'b0; bus32.abort = 1'b0; bus32.in = '0;
    bus16.go = 1'b0; bus16.abort = 1'b0; bus16.in = '0;

    // 1. reset
    tick(); tick();
    check("rst_cs",     64'(bus32.cs),     64'd0);
    check("rst_result", 64'(bus32.result), 64'd0);
    check("rst_done",   64'(bus32.done),   64'd0);
    check("rst_error",  64'(bus32.error),  64'd0);
    check("rst_busy",   64'(bus32.busy),   64'd0);
    rst = 1'b0;

    // 2. 5! = 120 after 6 edges, held afterwards
    run32(4'd5, e);
    check("t2_latency", 64'(e), 64'd6);
    check("t2_result",  64'(bus32.result), 64'd120);
    check("t2_done",    64'(bus32.done), 64'd1);
    check("t2_error",   64'(bus32.error), 64'd0);
    tick(); tick();
    check("t2_hold_res",  64'(bus32.result), 64'd120);
    check("t2_hold_done", 64'(bus32.done), 64'd1);
    check("t2_hold_cs",   64'(bus32.cs), 64'd3);

    // 3. 12! fits, 13! overflows 32 bits
    run32(4'd12, e);
    check("t3_latency", 64'(e), 64'd13);
    check("t3_result",  64'(bus32.result), 64'd479001600);
    run32(4'd13, e);
    check("t3_err_lat", 64'(e <= 14), 64'd1);
    check("t3_error",   64'(bus32.error), 64'd1);
    check("t3_sat",     64'(bus32.result), 64'hFFFF_FFFF);
    check("t3_done",    64'(bus32.done), 64'd0);
    check("t3_cs",      64'(bus32.cs), 64'd4);

    // 4. 0! and 1!
    run32(4'd0, e);
    check("t4_lat0",   64'(e), 64'd2);
    check("t4_res0",   64'(bus32.result), 64'd1);
    check("t4_err0",   64'(bus32.error), 64'd0);
    check("t4_busy0",  64'(bus32.busy), 64'd0);
    run32(4'd1, e);
    check("t4_lat1",   64'(e), 64'd2);
    check("t4_res1",   64'(bus32.result), 64'd1);
    check("t4_done1",  64'(bus32.done), 64'd1);

    // 15! overflows early
    run32(4'd15, e);
    check("max_error", 64'(bus32.error), 64'd1);
    check("max_sat",   64'(bus32.result), 64'hFFFF_FFFF);

    // 5. abort on third MULT cycle of 10!
    run32(4'd5, e);
    check("t5_pre", 64'(bus32.result), 64'd120);
    bus32.in = 4'd10;
    bus32.go = 1'b1;
    tick();
    bus32.go = 1'b0;
    tick(); tick(); tick();
    check("t5_mult_cs", 64'(bus32.cs), 64'd2);
    check("t5_stable",  64'(bus32.result), 64'd120);
    bus32.abort = 1'b1;
    tick();
    check("t5_cs",     64'(bus32.cs), 64'd0);
    check("t5_result", 64'(bus32.result), 64'd120);
    check("t5_done",   64'(bus32.done), 64'd0);
    check("t5_error",  64'(bus32.error), 64'd0);
    check("t5_busy",   64'(bus32.busy), 64'd0);
    // abort outranks go
    bus32.go = 1'b1;
    tick();
    check("t5_abort_go", 64'(bus32.cs), 64'd0);
    bus32.abort = 1'b0;
    bus32.go = 1'b0;
    tick();

    // 6. go held high: back-to-back 3! runs
    bus32.in = 4'd3;
    bus32.go = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t6_cs",   64'(bus32.cs), 64'(pat[i % 4]));
      check("t6_done", 64'(bus32.done), 64'(pat[i % 4] == 3'd3));
      if (pat[i % 4] == 3'd3) check("t6_result", 64'(bus32.result), 64'd6);
    end
    bus32.go = 1'b0;
    tick();
    check("t6_hold", 64'(bus32.cs), 64'd3);

    // 16-bit result width
    run16(4'd8, e);
    check("w16_lat8",  64'(e), 64'd9);
    check("w16_res8",  64'(bus16.result), 64'd40320);
    check("w16_done8", 64'(bus16.done), 64'd1);
    run16(4'd9, e);
    check("w16_err9",  64'(bus16.error), 64'd1);
    check("w16_sat9",  64'(bus16.result), 64'hFFFF);

    // reset mid-MULT discards the run
    bus32.in = 4'd6;
    bus32.go = 1'b1;
    tick();
    bus32.go = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_mid_cs",     64'(bus32.cs), 64'd0);
    check("rst_mid_result", 64'(bus32.result), 64'd0);
    check("rst_mid_busy",   64'(bus32.busy), 64'd0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
